// File: rtl/conv2d_dmem_ctrl_pkg.sv
// Shared types and constants for the conv2D IO-DMem controller.
package conv2d_dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD      = 2'd1,
    ST_WR      = 2'd2,
    ST_WR_RESP = 2'd3
  } state_e;

  // Channel identity, used to remember which burst type was granted last.
  typedef enum logic {
    CH_READ  = 1'b0,
    CH_WRITE = 1'b1
  } chan_e;

  localparam logic       WR_STATUS_OK = 1'b1;
  localparam int         MAX_INFLIGHT = 2;
  localparam logic [3:0] WE_ALL       = 4'hF;

  // A zero-length request still moves one beat.
  function automatic logic [31:0] burst_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/conv2d_dmem_ctrl_resp_fifo.sv
// 2-entry read-response FIFO with fall-through when empty, so a DMem word
// can be presented to the consumer in the same cycle it leaves the memory.
module conv2d_dmem_ctrl_resp_fifo #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DWIDTH-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  output logic [1:0]        count_o
);

  logic [DWIDTH-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              empty;
  logic              pop_eff;
  logic              store;
  logic              take;

  assign empty   = (count_q == 2'd0);
  assign valid_o = ~empty | push_i;
  assign data_o  = empty ? push_data_i : mem_q[rd_ptr_q];
  assign pop_eff = pop_i & valid_o;
  // A word that arrives into an empty FIFO and is consumed at once is never stored.
  assign store   = push_i & ~(empty & pop_eff);
  assign take    = pop_eff & ~empty;
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_q ^ store;
      rd_ptr_q <= rd_ptr_q ^ take;
      count_q  <= count_q + {1'b0, store} - {1'b0, take};
    end
  end

  // Data storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/conv2d_dmem_ctrl.sv
// Serializes burst read/write requests from the conv2D accelerator onto a
// single-port synchronous DMem with 1-cycle read latency.
module conv2d_dmem_ctrl
  import conv2d_dmem_ctrl_pkg::*;
#(
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int DMEM_AWIDTH = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AWIDTH-1:0]      req_read_addr,
  input  logic                   req_read_addr_valid,
  output logic                   req_read_addr_ready,
  input  logic [31:0]            req_read_len,
  output logic [DWIDTH-1:0]      resp_read_data,
  output logic                   resp_read_data_valid,
  input  logic                   resp_read_data_ready,
  input  logic [AWIDTH-1:0]      req_write_addr,
  input  logic                   req_write_addr_valid,
  output logic                   req_write_addr_ready,
  input  logic [31:0]            req_write_len,
  input  logic [DWIDTH-1:0]      req_write_data,
  input  logic                   req_write_data_valid,
  output logic                   req_write_data_ready,
  output logic                   resp_write_status,
  output logic                   resp_write_status_valid,
  input  logic                   resp_write_status_ready,
  output logic [DMEM_AWIDTH-1:0] dmem_addr,
  output logic [DWIDTH-1:0]      dmem_din,
  output logic [3:0]             dmem_we,
  output logic                   dmem_en,
  input  logic [DWIDTH-1:0]      dmem_dout
);

  state_e                 state_q, state_d;
  chan_e                  rr_last_q, rr_last_d;
  logic [DMEM_AWIDTH-1:0] addr_q, addr_d;
  logic [31:0]            len_q, len_d;
  logic [31:0]            cnt_q, cnt_d;
  logic                   inflight_q, inflight_d;
  logic [1:0]             fifo_count;
  logic [2:0]             occ;
  logic                   rd_grant;
  logic                   wr_grant;
  logic                   unused_addr_bits;

  // Upper request-address bits are dropped: DMem addressing wraps.
  assign unused_addr_bits = ^{req_read_addr[AWIDTH-1:DMEM_AWIDTH],
                              req_write_addr[AWIDTH-1:DMEM_AWIDTH]};

  // Round-robin: on contention, serve the channel that was not served last.
  assign rd_grant = req_read_addr_valid & (~req_write_addr_valid | (rr_last_q == CH_WRITE));
  assign wr_grant = req_write_addr_valid & (~req_read_addr_valid | (rr_last_q == CH_READ));

  // Words buffered plus the one possibly coming out of DMem this cycle.
  assign occ = {1'b0, fifo_count} + {2'b00, inflight_q};

  assign dmem_addr         = addr_q;
  assign dmem_din          = req_write_data;
  assign resp_write_status = WR_STATUS_OK;

  conv2d_dmem_ctrl_resp_fifo #(.DWIDTH(DWIDTH)) u_resp_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (dmem_dout),
    .pop_i       (resp_read_data_ready),
    .data_o      (resp_read_data),
    .valid_o     (resp_read_data_valid),
    .count_o     (fifo_count)
  );

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rr_last_q  <= CH_WRITE;
      addr_q     <= '0;
      len_q      <= 32'd1;
      cnt_q      <= 32'd0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // Arbitration, burst sequencing, DMem strobes and handshake outputs.
  always_comb begin
    state_d                 = state_q;
    rr_last_d               = rr_last_q;
    addr_d                  = addr_q;
    len_d                   = len_q;
    cnt_d                   = cnt_q;
    inflight_d              = 1'b0;
    req_read_addr_ready     = 1'b0;
    req_write_addr_ready    = 1'b0;
    req_write_data_ready    = 1'b0;
    resp_write_status_valid = 1'b0;
    dmem_en                 = 1'b0;
    dmem_we                 = 4'h0;
    case (state_q)
      ST_IDLE: begin
        // Readies are held low while reset is asserted.
        req_read_addr_ready  = rd_grant & rst;
        req_write_addr_ready = wr_grant & rst;
        if (rd_grant) begin
          state_d   = ST_RD;
          addr_d    = req_read_addr[DMEM_AWIDTH-1:0];
          len_d     = burst_len(req_read_len);
          cnt_d     = 32'd0;
          rr_last_d = CH_READ;
        end else if (wr_grant) begin
          state_d   = ST_WR;
          addr_d    = req_write_addr[DMEM_AWIDTH-1:0];
          len_d     = burst_len(req_write_len);
          cnt_d     = 32'd0;
          rr_last_d = CH_WRITE;
        end
      end
      ST_RD: begin
        // Only issue when the FIFO is guaranteed room for the returning word.
        if ((cnt_q != len_q) && (occ < 3'(MAX_INFLIGHT))) begin
          dmem_en    = 1'b1;
          inflight_d = 1'b1;
          addr_d     = addr_q + DMEM_AWIDTH'(1);
          cnt_d      = cnt_q + 32'd1;
        end else if ((cnt_q == len_q) && !inflight_q && (fifo_count == 2'd0)) begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        req_write_data_ready = 1'b1;
        if (req_write_data_valid) begin
          dmem_en = 1'b1;
          dmem_we = WE_ALL;
          addr_d  = addr_q + DMEM_AWIDTH'(1);
          cnt_d   = cnt_q + 32'd1;
          if ((cnt_q + 32'd1) == len_q) state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        resp_write_status_valid = 1'b1;
        if (resp_write_status_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv2d_dmem_ctrl.sv
// Directed bench for conv2d_dmem_ctrl with a transaction-level reference model.
module tb_conv2d_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] req_read_addr;
  logic        req_read_addr_valid;
  logic        req_read_addr_ready;
  logic [31:0] req_read_len;
  logic [31:0] resp_read_data;
  logic        resp_read_data_valid;
  logic        resp_read_data_ready;
  logic [31:0] req_write_addr;
  logic        req_write_addr_valid;
  logic        req_write_addr_ready;
  logic [31:0] req_write_len;
  logic [31:0] req_write_data;
  logic        req_write_data_valid;
  logic        req_write_data_ready;
  logic        resp_write_status;
  logic        resp_write_status_valid;
  logic        resp_write_status_ready;
  logic [13:0] dmem_addr;
  logic [31:0] dmem_din;
  logic [3:0]  dmem_we;
  logic        dmem_en;
  logic [31:0] dmem_dout;

  conv2d_dmem_ctrl dut (
    .clk                     (clk),
    .rst                     (rst),
    .req_read_addr           (req_read_addr),
    .req_read_addr_valid     (req_read_addr_valid),
    .req_read_addr_ready     (req_read_addr_ready),
    .req_read_len            (req_read_len),
    .resp_read_data          (resp_read_data),
    .resp_read_data_valid    (resp_read_data_valid),
    .resp_read_data_ready    (resp_read_data_ready),
    .req_write_addr          (req_write_addr),
    .req_write_addr_valid    (req_write_addr_valid),
    .req_write_addr_ready    (req_write_addr_ready),
    .req_write_len           (req_write_len),
    .req_write_data          (req_write_data),
    .req_write_data_valid    (req_write_data_valid),
    .req_write_data_ready    (req_write_data_ready),
    .resp_write_status       (resp_write_status),
    .resp_write_status_valid (resp_write_status_valid),
    .resp_write_status_ready (resp_write_status_ready),
    .dmem_addr               (dmem_addr),
    .dmem_din                (dmem_din),
    .dmem_we                 (dmem_we),
    .dmem_en                 (dmem_en),
    .dmem_dout               (dmem_dout)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DMem: synchronous single port, read data one cycle after the access.
  logic [31:0] mem [0:16383];
  always @(posedge clk) begin
    if (dmem_en) begin
      if (dmem_we == 4'hF) mem[dmem_addr] <= dmem_din;
      else                 dmem_dout      <= mem[dmem_addr];
    end
  end

  // Read consumer: 0 = always ready, 1 = repeating 1,0,0,1 pattern.
  int rdy_mode = 0;
  int rdy_ph = 0;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) begin
      resp_read_data_ready = (rdy_ph == 0 || rdy_ph == 3);
      rdy_ph = (rdy_ph + 1) % 4;
    end else begin
      resp_read_data_ready = 1'b1;
    end
  end

  // Reference model: each accepted burst expands into the exact word
  // addresses it must touch and the data each read beat must carry.
  logic [13:0] exp_rd_addr[$];
  logic [31:0] exp_rd_data[$];
  logic [13:0] exp_wr_addr[$];
  logic [31:0] rx_log[$];
  logic [13:0] iss_log[$];
  int          wr_pending = 0;
  int          issued = 0;
  int          popped = 0;
  int          m_n;
  logic [13:0] m_a;

  always @(negedge clk) begin
    if (!rst) begin
      exp_rd_addr.delete();
      exp_rd_data.delete();
      exp_wr_addr.delete();
      wr_pending = 0;
      issued     = 0;
      popped     = 0;
    end else begin
      if (dmem_en && dmem_we == 4'h0) begin
        if (exp_rd_addr.size() == 0) chk("rd_issue_extra", 32'(dmem_en), 32'd0);
        else begin
          chk("rd_issue_addr", 32'(dmem_addr), 32'(exp_rd_addr.pop_front()));
          chk("rd_outstanding_lt2", (issued - popped < 2) ? 32'd1 : 32'd0, 32'd1);
          iss_log.push_back(dmem_addr);
          issued++;
        end
      end
      if (req_write_data_valid && req_write_data_ready) begin
        if (exp_wr_addr.size() == 0) chk("wr_beat_extra", 32'(req_write_data_ready), 32'd0);
        else begin
          chk("wr_en", 32'(dmem_en), 32'd1);
          chk("wr_we", 32'(dmem_we), 32'hF);
          chk("wr_addr", 32'(dmem_addr), 32'(exp_wr_addr.pop_front()));
          chk("wr_din", dmem_din, req_write_data);
        end
      end else if (dmem_we != 4'h0) begin
        chk("wr_we_unaccepted", 32'(dmem_we), 32'd0);
      end
      if (resp_read_data_valid) begin
        if (exp_rd_data.size() == 0) chk("rd_beat_extra", 32'(resp_read_data_valid), 32'd0);
        else if (resp_read_data_ready) begin
          chk("rd_data", resp_read_data, exp_rd_data.pop_front());
          rx_log.push_back(resp_read_data);
          popped++;
        end
      end
      if (resp_write_status_valid) begin
        if (wr_pending == 0 || exp_wr_addr.size() != 0)
          chk("status_early", 32'(resp_write_status_valid), 32'd0);
        else begin
          chk("status_ok", 32'(resp_write_status), 32'd1);
          if (resp_write_status_ready) wr_pending--;
        end
      end
      if (req_read_addr_valid && req_read_addr_ready) begin
        m_n = (req_read_len == 32'd0) ? 1 : int'(req_read_len);
        issued = 0;
        popped = 0;
        for (int i = 0; i < m_n; i++) begin
          m_a = req_read_addr[13:0] + 14'(i);
          exp_rd_addr.push_back(m_a);
          exp_rd_data.push_back(mem[m_a]);
        end
      end
      if (req_write_addr_valid && req_write_addr_ready) begin
        m_n = (req_write_len == 32'd0) ? 1 : int'(req_write_len);
        for (int i = 0; i < m_n; i++) exp_wr_addr.push_back(req_write_addr[13:0] + 14'(i));
        wr_pending++;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_rd(input logic [31:0] a, input logic [31:0] l);
    int k;
    req_read_addr = a; req_read_len = l; req_read_addr_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!req_read_addr_ready && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) chk("rd_addr_accept_timeout", 32'(req_read_addr_ready), 32'd1);
    @(posedge clk); #1;
    req_read_addr_valid = 1'b0;
  endtask

  task automatic send_wr(input logic [31:0] a, input logic [31:0] l);
    int k;
    req_write_addr = a; req_write_len = l; req_write_addr_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!req_write_addr_ready && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) chk("wr_addr_accept_timeout", 32'(req_write_addr_ready), 32'd1);
    @(posedge clk); #1;
    req_write_addr_valid = 1'b0;
  endtask

  task automatic wr_beat(input logic [31:0] d, input int gap);
    int k;
    repeat (gap) begin @(posedge clk); #1; end
    req_write_data = d; req_write_data_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!req_write_data_ready && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) chk("wr_beat_timeout", 32'(req_write_data_ready), 32'd1);
    @(posedge clk); #1;
    req_write_data_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    @(negedge clk);
    while ((exp_rd_data.size() != 0 || exp_rd_addr.size() != 0 || wr_pending != 0 ||
            resp_read_data_valid) && k < 300) begin
      @(negedge clk); k++;
    end
    if (k >= 300) chk("burst_done_timeout", 32'(exp_rd_data.size() + exp_wr_addr.size()), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int r0;
  int i0;

  initial begin
    rst = 1'b0;
    req_read_addr = 32'h30; req_read_len = 32'd1;
    req_write_addr = 32'h80; req_write_len = 32'd1;
    req_write_data = 32'd0; req_write_data_valid = 1'b0;
    resp_write_status_ready = 1'b1;
    for (int i = 0; i < 16384; i++) mem[i] = 32'hA500_0000 | i;
    mem[32'h10] = 32'hDEADBEEF;
    // Both requests pending through reset: nothing may be accepted yet.
    req_read_addr_valid = 1'b1; req_write_addr_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_addr_ready", 32'(req_read_addr_ready), 32'd0);
    chk("rst_wr_addr_ready", 32'(req_write_addr_ready), 32'd0);
    chk("rst_wr_data_ready", 32'(req_write_data_ready), 32'd0);
    chk("rst_rd_valid", 32'(resp_read_data_valid), 32'd0);
    chk("rst_status_valid", 32'(resp_write_status_valid), 32'd0);
    chk("rst_dmem_en", 32'(dmem_en), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Contention right after reset: read wins, then write wins.
    @(negedge clk);
    chk("arb1_rd_ready", 32'(req_read_addr_ready), 32'd1);
    chk("arb1_wr_ready", 32'(req_write_addr_ready), 32'd0);
    @(posedge clk); #1;
    req_read_addr_valid = 1'b0; req_write_addr_valid = 1'b0;
    wait_done();
    req_read_addr_valid = 1'b1; req_write_addr_valid = 1'b1;
    @(negedge clk);
    chk("arb2_rd_ready", 32'(req_read_addr_ready), 32'd0);
    chk("arb2_wr_ready", 32'(req_write_addr_ready), 32'd1);
    @(posedge clk); #1;
    req_read_addr_valid = 1'b0; req_write_addr_valid = 1'b0;
    wr_beat(32'h55, 0);
    wait_done();
    chk("arb_wr_mem", mem[32'h80], 32'h0000_0055);

    // Single-beat read latency.
    send_rd(32'h10, 32'd1);
    @(negedge clk);
    chk("lat_en_t1", 32'(dmem_en), 32'd1);
    chk("lat_addr_t1", 32'(dmem_addr), 32'h10);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_valid_t2", 32'(resp_read_data_valid), 32'd1);
    chk("lat_data_t2", resp_read_data, 32'hDEADBEEF);
    wait_done();

    // 9-beat read under consumer backpressure.
    rdy_mode = 1;
    r0 = rx_log.size();
    send_rd(32'h20, 32'd9);
    wait_done();
    rdy_mode = 0;
    chk("len9_count", 32'(rx_log.size() - r0), 32'd9);
    if (rx_log.size() - r0 == 9) begin
      chk("len9_first", rx_log[r0], 32'hA500_0020);
      chk("len9_last", rx_log[r0 + 8], 32'hA500_0028);
    end

    // 4-beat write with gaps; status held until accepted.
    resp_write_status_ready = 1'b0;
    send_wr(32'h40, 32'd4);
    wr_beat(32'd1, 0);
    wr_beat(32'd2, 1);
    wr_beat(32'd3, 2);
    wr_beat(32'd4, 1);
    repeat (3) begin
      @(negedge clk);
      chk("status_held", 32'(resp_write_status_valid), 32'd1);
      @(posedge clk); #1;
    end
    resp_write_status_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("status_drop", 32'(resp_write_status_valid), 32'd0);
    for (int i = 0; i < 4; i++) chk("wr4_mem", mem[32'h40 + i], 32'(i + 1));
    wait_done();

    // Zero length and address wrap.
    i0 = iss_log.size();
    send_rd(32'h0000_3FFF, 32'd0);
    wait_done();
    chk("len0_issues", 32'(iss_log.size() - i0), 32'd1);
    if (iss_log.size() - i0 == 1) chk("len0_addr", 32'(iss_log[i0]), 32'h3FFF);
    i0 = iss_log.size();
    r0 = rx_log.size();
    send_rd(32'h0001_3FFF, 32'd3);
    wait_done();
    chk("wrap_issues", 32'(iss_log.size() - i0), 32'd3);
    if (iss_log.size() - i0 == 3) begin
      chk("wrap_addr0", 32'(iss_log[i0]), 32'h3FFF);
      chk("wrap_addr1", 32'(iss_log[i0 + 1]), 32'h0000);
      chk("wrap_addr2", 32'(iss_log[i0 + 2]), 32'h0001);
    end
    if (rx_log.size() - r0 == 3) chk("wrap_data1", rx_log[r0 + 1], 32'hA500_0000);

    // Reset in the middle of an 8-beat read.
    r0 = rx_log.size();
    send_rd(32'h100, 32'd8);
    i0 = 0;
    while (rx_log.size() - r0 < 3 && i0 < 100) begin @(negedge clk); i0++; end
    if (i0 >= 100) chk("mid_rst_progress", 32'(rx_log.size() - r0), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_rd_valid", 32'(resp_read_data_valid), 32'd0);
    chk("midrst_dmem_en", 32'(dmem_en), 32'd0);
    chk("midrst_wr_data_ready", 32'(req_write_data_ready), 32'd0);
    chk("midrst_status_valid", 32'(resp_write_status_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_en", 32'(dmem_en), 32'd0);
    chk("post_rst_idle_valid", 32'(resp_read_data_valid), 32'd0);
    @(posedge clk); #1;
    r0 = rx_log.size();
    send_rd(32'h200, 32'd2);
    wait_done();
    chk("post_rst_count", 32'(rx_log.size() - r0), 32'd2);
    if (rx_log.size() - r0 == 2) begin
      chk("post_rst_d0", rx_log[r0], 32'hA500_0200);
      chk("post_rst_d1", rx_log[r0 + 1], 32'hA500_0201);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
